// File: rtl/hv_dac_spi_ctrl.sv
// rtl/hv_dac_spi_ctrl.sv - HV bias DAC set-point shadow and SPI frame serializer
//
// Purpose: holds 32 HV bias set-points (4 DAC chips x 8 channels, 12 bit),
// written and read over the DTC slow-command register bus. Each changed
// set-point is shifted out as a 16-bit SPI frame {0, ch[2:0], value[11:0]},
// MSB first. One LDAC pulse is issued per batch of frames.
//
// Optional feature macro: HV_DAC_RAMP_EN
//   When defined, each frame moves a channel at most RAMP_STEP codes from the
//   last value sent. Channels that have not reached their target are queued
//   again for the next sweep, and LDAC is pulsed after every sweep.
//
// Ports:
//   dtc_clk        system clock
//   rst            synchronous active-high reset
//   reg_wr/reg_rd  one-cycle write / read strobes
//   reg_addr       bit31 = read flag, bits[30:0] = register address
//   reg_wdata      write data, bits[11:0] used
//   reg_rdata      read data, valid while reg_ack is high, 0 otherwise
//   reg_ack        one-cycle acknowledge, the cycle after the strobe
//   busy           channels pending, batch open, or FSM not idle
//   hv_dac_sclk    SPI clock, idles high, DAC samples on the falling edge
//   hv_dac_din     SPI data, MSB first
//   hv_dac_sync_b  per-chip frame select, active low
//   hv_dac_load_b  LDAC, active low

module hv_dac_spi_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h60,
    parameter logic [31:0] REFRESH_ADDR = 32'h5F,
    parameter int unsigned SCLK_DIV     = 2,
    parameter int unsigned LDAC_W       = 4,
    parameter int unsigned RAMP_STEP    = 64
) (
    input  logic        dtc_clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    output logic        busy,
    output logic        hv_dac_sclk,
    output logic        hv_dac_din,
    output logic [3:0]  hv_dac_sync_b,
    output logic        hv_dac_load_b
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DIV_M1  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] PER_M1  = CW'(2 * SCLK_DIV - 1);
    localparam logic [CW-1:0] LDAC_M1 = CW'(LDAC_W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    // Register bus decode
    logic [30:0] off;
    logic        in_win, is_refresh, wr_win, wr_ref, rd_ok;
    logic [4:0]  widx;
    logic        unused_wdata;

    assign off          = reg_addr[30:0] - BASE_ADDR[30:0];
    assign in_win       = (off < 31'd32);
    assign is_refresh   = (reg_addr[30:0] == REFRESH_ADDR[30:0]);
    assign widx         = off[4:0];
    assign wr_win       = reg_wr & in_win;
    assign wr_ref       = reg_wr & is_refresh;
    // A simultaneous write wins; the read is dropped.
    assign rd_ok        = reg_rd & ~reg_wr & reg_addr[31] & (in_win | is_refresh);
    assign unused_wdata = ^reg_wdata[31:12];

    logic [11:0] shadow_q [32];
    logic [31:0] pending_q, pending_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;

    // FSM state
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    frame_q, frame_d;
    logic [1:0]     chip_q, chip_d;
    logic           batch_q, batch_d;
    logic           sclk_q, sclk_d;
    logic           din_q, din_d;
    logic [3:0]     sync_b_q, sync_b_d;
    logic           load_b_q, load_b_d;
    logic           start_frame, ldac_end, pick;

    // Lowest pending index is served first.
    logic [4:0]  sel_idx;
    logic [11:0] frame_val;

    always_comb begin
        sel_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 5'(i);
        end
    end

`ifdef HV_DAC_RAMP_EN
    localparam logic [11:0] STEP12 = 12'(RAMP_STEP);
    logic [11:0] sent_q [32];
    logic [31:0] repend_q;
    logic [11:0] tgt, cur;

    always_comb begin
        tgt = shadow_q[sel_idx];
        cur = sent_q[sel_idx];
        if (tgt > cur) begin
            frame_val = ((tgt - cur) > STEP12) ? (cur + STEP12) : tgt;
        end else begin
            frame_val = ((cur - tgt) > STEP12) ? (cur - STEP12) : tgt;
        end
    end
`else
    assign frame_val = shadow_q[sel_idx];
`endif

    // Pending mask: the FSM clears the bit it picks, then bus writes set bits,
    // so a write landing on the channel being picked is queued again.
    always_comb begin
        pending_d = pending_q;
        if (start_frame) pending_d[sel_idx] = 1'b0;
`ifdef HV_DAC_RAMP_EN
        if (ldac_end) pending_d = pending_d | repend_q;
`endif
        if (wr_ref) begin
            pending_d = '1;
        end else if (wr_win) begin
            pending_d[widx] = 1'b1;
        end
    end

    always_comb begin
        ack_d   = wr_win | wr_ref | rd_ok;
        rdata_d = '0;
        if (rd_ok) begin
            rdata_d = in_win ? {20'b0, shadow_q[widx]} : pending_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        chip_d      = chip_q;
        batch_d     = batch_q;
        start_frame = 1'b0;
        ldac_end    = 1'b0;
        pick        = 1'b0;

        case (state_q)
            S_IDLE: pick = 1'b1;
            S_SETUP: begin
                if (cnt_q == DIV_M1) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SHIFT: begin
                // Advance data together with the SCLK rising edge.
                if (cnt_q == DIV_M1) frame_d = {frame_q[14:0], 1'b0};
                if (cnt_q == PER_M1) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_M1) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    batch_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                // The last gap cycle doubles as the IDLE decision so that
                // back-to-back frames repeat every SCLK_DIV*36 cycles.
                if (cnt_q == PER_M1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pick    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LDAC: begin
                if (cnt_q == LDAC_M1) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    batch_d  = 1'b0;
                    ldac_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pick) begin
            if (pending_q != '0) begin
                start_frame = 1'b1;
                state_d     = S_SETUP;
                cnt_d       = '0;
                frame_d     = {1'b0, sel_idx[2:0], frame_val};
                chip_d      = sel_idx[4:3];
            end else if (batch_q) begin
                state_d = S_LDAC;
                cnt_d   = '0;
            end
        end

        // Pin values are decoded from the next state and registered, so the
        // pins are glitch-free and line up with state_q.
        sync_b_d = 4'hF;
        sclk_d   = 1'b1;
        din_d    = 1'b0;
        load_b_d = 1'b1;
        if (state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD) begin
            sync_b_d = ~(4'b0001 << chip_d);
            din_d    = frame_d[15];
        end
        if (state_d == S_SHIFT && cnt_d <= DIV_M1) sclk_d = 1'b0;
        if (state_d == S_LDAC) load_b_d = 1'b0;
    end

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
            pending_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            chip_q    <= '0;
            batch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            sync_b_q  <= 4'hF;
            load_b_q  <= 1'b1;
        end else begin
            if (wr_win) shadow_q[widx] <= reg_wdata[11:0];
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            chip_q    <= chip_d;
            batch_q   <= batch_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            sync_b_q  <= sync_b_d;
            load_b_q  <= load_b_d;
        end
    end

`ifdef HV_DAC_RAMP_EN
    // Channels short of their target wait in repend_q until the sweep's LDAC.
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) sent_q[i] <= '0;
            repend_q <= '0;
        end else begin
            if (ldac_end) repend_q <= '0;
            if (start_frame) begin
                sent_q[sel_idx] <= frame_val;
                if (frame_val != tgt) repend_q[sel_idx] <= 1'b1;
            end
        end
    end

    assign busy = (pending_q != '0) | (repend_q != '0) | batch_q | (state_q != S_IDLE);
`else
    assign busy = (pending_q != '0) | batch_q | (state_q != S_IDLE);
`endif

    assign reg_rdata     = rdata_q;
    assign reg_ack       = ack_q;
    assign hv_dac_sclk   = sclk_q;
    assign hv_dac_din    = din_q;
    assign hv_dac_sync_b = sync_b_q;
    assign hv_dac_load_b = load_b_q;

endmodule

// File: tb/tb_hv_dac_spi_ctrl.sv
// tb/tb_hv_dac_spi_ctrl.sv - directed bench for hv_dac_spi_ctrl

module tb_hv_dac_spi_ctrl;

    logic        dtc_clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [31:0] reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        busy;
    logic        hv_dac_sclk;
    logic        hv_dac_din;
    logic [3:0]  hv_dac_sync_b;
    logic        hv_dac_load_b;

    hv_dac_spi_ctrl dut (
        .dtc_clk       (dtc_clk),
        .rst           (rst),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .reg_ack       (reg_ack),
        .busy          (busy),
        .hv_dac_sclk   (hv_dac_sclk),
        .hv_dac_din    (hv_dac_din),
        .hv_dac_sync_b (hv_dac_sync_b),
        .hv_dac_load_b (hv_dac_load_b)
    );

    always #5 dtc_clk = ~dtc_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI monitor: decodes frames on SCLK falling edges while a chip is selected.
    logic [17:0] frames [$];
    int          falls [$];
    int          lens [$];
    int          nbits [$];
    int          cyc = 0;
    int          ldac_n = 0;
    int          ldac_start = 0;
    int          ldac_w = 0;
    int          ldac_frames = 0;
    int          last_rise = 0;
    int          rise_to_ldac = 0;
    int          multi = 0;
    logic        prev_sclk = 1'b1;
    logic [3:0]  prev_sync = 4'hF;
    logic        prev_load = 1'b1;
    logic [15:0] sh = '0;
    int          nb = 0;
    logic [1:0]  cchip = '0;
    int          fall_c = 0;

    always @(negedge dtc_clk) begin
        cyc++;
        if (hv_dac_sync_b != 4'hF) begin
            if ($countones(~hv_dac_sync_b) > 1) multi++;
            if (prev_sync == 4'hF) begin
                sh = '0;
                nb = 0;
                fall_c = cyc;
                falls.push_back(cyc);
                for (int i = 0; i < 4; i++) if (!hv_dac_sync_b[i]) cchip = 2'(i);
            end else if (hv_dac_sync_b != prev_sync) begin
                multi++;
            end
            if (prev_sclk && !hv_dac_sclk) begin
                sh = {sh[14:0], hv_dac_din};
                nb++;
            end
        end else if (prev_sync != 4'hF) begin
            frames.push_back({cchip, sh});
            lens.push_back(cyc - fall_c);
            nbits.push_back(nb);
            last_rise = cyc;
        end
        if (!hv_dac_load_b && prev_load) begin
            ldac_n++;
            ldac_start = cyc;
            ldac_frames = frames.size();
            rise_to_ldac = cyc - last_rise;
        end
        if (hv_dac_load_b && !prev_load) ldac_w = cyc - ldac_start;
        prev_sclk = hv_dac_sclk;
        prev_sync = hv_dac_sync_b;
        prev_load = hv_dac_load_b;
    end

    // All register tasks start and end on a negedge; strobes last one cycle.
    task automatic reg_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic exp_ack);
        reg_wr = 1'b1;
        reg_addr = a;
        reg_wdata = d;
        @(negedge dtc_clk);
        reg_wr = 1'b0;
        check({tag, "_ack"}, {31'b0, reg_ack}, {31'b0, exp_ack});
    endtask

    task automatic reg_read(input string tag, input logic [31:0] a, input logic exp_ack,
                            input logic [31:0] exp_data);
        reg_rd = 1'b1;
        reg_addr = a;
        @(negedge dtc_clk);
        reg_rd = 1'b0;
        check({tag, "_ack"}, {31'b0, reg_ack}, {31'b0, exp_ack});
        check({tag, "_rdata"}, reg_rdata, exp_data);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge dtc_clk);
            n++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        @(negedge dtc_clk);
    endtask

    function automatic logic [31:0] frame_at(input int k);
        if (k < frames.size()) return {14'b0, frames[k]};
        return 32'hDEAD_BEEF;
    endfunction

    logic [11:0] model [32];
    int fb, lb;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge dtc_clk);
        check("rst_sclk", {31'b0, hv_dac_sclk}, 32'd1);
        check("rst_din", {31'b0, hv_dac_din}, 32'd0);
        check("rst_sync", {28'b0, hv_dac_sync_b}, 32'hF);
        check("rst_load", {31'b0, hv_dac_load_b}, 32'd1);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_ack", {31'b0, reg_ack}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge dtc_clk);

        // Single frame on chip 0
        fb = frames.size();
        lb = ldac_n;
        reg_write("w60", 32'h60, 32'h33, 1'b1);
        model[0] = 12'h033;
        wait_idle("w60", 300);
        check("w60_nframes", frames.size() - fb, 32'd1);
        check("w60_frame", frame_at(fb), {14'b0, 2'd0, 16'h0033});
        check("w60_bits", nbits[fb], 32'd16);
        check("w60_synclen", lens[fb], 32'd68);
        check("w60_nldac", ldac_n - lb, 32'd1);
        check("w60_ldacw", ldac_w, 32'd4);
        check("w60_gap", rise_to_ldac, 32'd4);

        // Second write lands while the first frame is in flight
        fb = frames.size();
        lb = ldac_n;
        reg_write("w61", 32'h61, 32'h77, 1'b1);
        model[1] = 12'h077;
        repeat (20) @(negedge dtc_clk);
        reg_write("w62", 32'h62, 32'h99, 1'b1);
        model[2] = 12'h099;
        wait_idle("w6162", 500);
        check("w6162_nframes", frames.size() - fb, 32'd2);
        check("w61_frame", frame_at(fb), {14'b0, 2'd0, 16'h1077});
        check("w62_frame", frame_at(fb + 1), {14'b0, 2'd0, 16'h2099});
        check("w6162_period", falls[fb + 1] - falls[fb], 32'd72);
        check("w6162_nldac", ldac_n - lb, 32'd1);
        check("w6162_ldac_after", ldac_frames - fb, 32'd2);

        // Chip 2, channel 1
        fb = frames.size();
        reg_write("w71", 32'h71, 32'hF0, 1'b1);
        model[17] = 12'h0F0;
        wait_idle("w71", 300);
        check("w71_frame", frame_at(fb), {14'b0, 2'd2, 16'h10F0});

        // Reads and ignored accesses
        reg_read("r60", 32'h8000_0060, 1'b1, 32'h033);
        reg_read("r71", 32'h8000_0071, 1'b1, 32'h0F0);
        reg_read("r61", 32'h8000_0061, 1'b1, 32'h077);
        reg_read("r40", 32'h8000_0040, 1'b0, 32'h0);
        reg_read("r80", 32'h8000_0080, 1'b0, 32'h0);
        reg_write("w40", 32'h40, 32'h123, 1'b0);
        check("w40_busy", {31'b0, busy}, 32'd0);

        // Write and read strobed together: write wins, read dropped
        fb = frames.size();
        reg_wr = 1'b1;
        reg_rd = 1'b1;
        reg_addr = 32'h8000_0063;
        reg_wdata = 32'hFFFF_F05A;
        @(negedge dtc_clk);
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        check("wr_rd_ack", {31'b0, reg_ack}, 32'd1);
        check("wr_rd_rdata", reg_rdata, 32'd0);
        @(negedge dtc_clk);
        check("wr_rd_single_ack", {31'b0, reg_ack}, 32'd0);
        model[3] = 12'h05A;
        wait_idle("w63", 300);
        check("w63_frame", frame_at(fb), {14'b0, 2'd0, 16'h305A});

        // Refresh: all 32 channels in index order, one LDAC
        fb = frames.size();
        lb = ldac_n;
        reg_write("wref", 32'h5F, 32'h0, 1'b1);
        reg_read("rref", 32'h8000_005F, 1'b1, 32'hFFFF_FFFF);
        wait_idle("ref", 32 * 72 + 200);
        check("ref_nframes", frames.size() - fb, 32'd32);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] ii;
            ii = 5'(i);
            check($sformatf("ref_frame%0d", i), frame_at(fb + i),
                  {14'b0, ii[4:3], 1'b0, ii[2:0], model[i]});
        end
        if (frames.size() >= fb + 32) check("ref_span", falls[fb + 31] - falls[fb], 32'd2232);
        check("ref_nldac", ldac_n - lb, 32'd1);
        check("ref_multi_sel", multi, 32'd0);
        reg_read("rref_end", 32'h8000_005F, 1'b1, 32'h0);

        // Reset in the middle of a frame
        lb = ldac_n;
        reg_write("w60b", 32'h60, 32'h44, 1'b1);
        repeat (10) @(negedge dtc_clk);
        check("mid_in_frame", {28'b0, hv_dac_sync_b}, 32'hE);
        rst = 1'b1;
        @(negedge dtc_clk);
        check("mid_sync", {28'b0, hv_dac_sync_b}, 32'hF);
        check("mid_sclk", {31'b0, hv_dac_sclk}, 32'd1);
        check("mid_load", {31'b0, hv_dac_load_b}, 32'd1);
        check("mid_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge dtc_clk);
        check("mid_no_ldac", ldac_n - lb, 32'd0);
        reg_read("r60_rst", 32'h8000_0060, 1'b1, 32'h0);
        reg_read("rref_rst", 32'h8000_005F, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hv_dac_spi_ctrl.md
Name: hv_dac_spi_ctrl

Overview:
Downstream consumer of the DTC slow-command register bus.
- Holds a 32-entry shadow of HV bias set-points: 4 DAC chips × 8 channels, 12 bit each.
- Serializes every changed set-point as a 16-bit SPI frame onto HV_DAC_SCLK / HV_DAC_DIN / HV_DAC_SYNC_B[3:0].
- Pulses HV_DAC_LOAD_B once per batch of frames.
- Answers slow-command reads with the shadow contents.

Parameters:
- BASE_ADDR, 32'h60: first set-point address; the window is BASE_ADDR..BASE_ADDR+31.
- REFRESH_ADDR, 32'h5F: a write here marks all 32 channels pending. A read here returns the pending mask.
- SCLK_DIV, 2: SCLK half-period, in dtc_clk cycles; must be ≥1.
- LDAC_W, 4: HV_DAC_LOAD_B low width, in dtc_clk cycles.
- RAMP_STEP, 64: maximum code change per frame; used only with HV_DAC_RAMP_EN.

Ports:
- dtc_clk  in  1  system clock (40 MHz DTC clock)
- rst  in  1  synchronous, active-high reset
- reg_wr  in  1  write strobe, one cycle
- reg_rd  in  1  read strobe, one cycle
- reg_addr  in  32  bit31 = read flag; bits[30:0] = register address
- reg_wdata  in  32  write data; bits[11:0] are used
- reg_rdata  out  32  read data; valid while reg_ack is high
- reg_ack  out  1  one-cycle acknowledge
- busy  out  1  high while any channel is pending or the FSM is not in IDLE
- hv_dac_sclk  out  1  SPI clock; idles high
- hv_dac_din  out  1  SPI data, MSB first
- hv_dac_sync_b  out  4  per-chip frame select, active low
- hv_dac_load_b  out  1  LDAC, active low

Behaviour:
- Reset:
  - All 32 shadow entries = 0; pending mask = 0.
  - hv_dac_sclk=1, hv_dac_din=0, hv_dac_sync_b=4'hF, hv_dac_load_b=1.
  - reg_rdata=0, reg_ack=0, busy=0; FSM in IDLE.
- Reset asserted mid-frame: outputs reach their reset values on the next edge; no LDAC pulse is issued.
- Channel index: idx = addr[30:0] − BASE_ADDR (0..31); chip = idx[4:3], ch = idx[2:0].
- Write, address in window:
  - shadow[idx] ← wdata[11:0]; pending[idx] ← 1.
  - reg_ack asserted the cycle after reg_wr.
- Write to REFRESH_ADDR: pending ← 32'hFFFFFFFF; reg_ack the cycle after reg_wr.
- Write outside both: ignored, no ack.
- Read (bit31 set):
  - reg_ack and reg_rdata the cycle after reg_rd.
  - In window: rdata = {20'b0, shadow[idx]}.
  - REFRESH_ADDR: rdata = pending mask.
  - Elsewhere: no ack, rdata holds 0.
- reg_wr and reg_rd in the same cycle: the write is serviced and the read is dropped; single ack.
- Frame word = {1'b0, ch[2:0], value[11:0]}, MSB first.
- FSM:
  - IDLE: if pending≠0, select the lowest set index, latch its value, clear its pending bit, → SETUP. If pending=0 and batch_flag=1, → LDAC.
  - SETUP: sync_b[chip]=0 for SCLK_DIV cycles; din = bit15.
  - SHIFT: 16 SCLK periods. SCLK falls (DAC samples) after SCLK_DIV cycles low phase start, then rises SCLK_DIV cycles later; din updates on each rising edge. After the 16th rising edge, → HOLD.
  - HOLD: sync_b still low, SCLK_DIV cycles; then sync_b=4'hF, batch_flag ← 1.
  - GAP: sync_b high for 2·SCLK_DIV cycles; → IDLE.
  - LDAC: load_b=0 for LDAC_W cycles, batch_flag ← 0; → IDLE.
- Frame length: SCLK_DIV·(1+32+1+2). With SCLK_DIV=2 this is 72 cycles.
- A write to a channel whose frame is in flight re-sets its pending bit; the new value is sent in a later frame. A frame is never corrupted.
- Chips are never selected simultaneously; at most one sync_b bit is low at any time.

Optional Feature:
HV_DAC_RAMP_EN:
- Defined:
  - A per-channel sent[] register exists, reset to 0.
  - The frame value is target if |target−sent| ≤ RAMP_STEP, otherwise sent±RAMP_STEP toward target.
  - sent is updated with the frame value.
  - The pending bit is re-set if the frame value ≠ target.
  - LDAC is issued after each sweep; readback returns the target.
- Undefined: frame value = shadow; no sent[] storage.

Test Plan:
- Write 0x60←0x33 → ack at +1; one frame on sync_b[0] with bits 0x0033; load_b low 4 cycles after HOLD+GAP; busy low afterwards.
- Write 0x61←0x77, then 0x62←0x99 while the first frame is in flight → frames 0x1077 then 0x2099 on sync_b[0]; exactly one LDAC, after the second frame.
- Write 0x71←0xF0 → idx 17 (chip 2, ch 1); frame 0x10F0 on sync_b[2]; other sync_b bits stay high.
- Read 0x80000060 → ack +1, rdata 0x033. Read 0x80000071 → 0x0F0. Read 0x80000040 → no ack.
- Write 0x5F, then immediately read 0x8000005F → rdata 0xFFFFFFFF; 32 frames in index order, 32·72 cycles; one LDAC; final read → 0.
- Assert rst during SHIFT of a 0x60 frame → sync_b=F, sclk=1, load_b=1 next cycle; read 0x80000060 after reset → 0.
